// File: rtl/delay_line_pkg.sv
// Shared types and constants for the delay-line sequencer and its multiply-accumulate stage.
package delay_line_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        READ,
        MIX,
        OUT
    } state_t;

    localparam int GAIN_FRAC = 8;
    localparam int DEF_ADR_W = 13;
    localparam int DEF_DAT_W = 8;

    function automatic int sample_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sample_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int SAMPLE_MAX = sample_max(DEF_DAT_W);
    localparam int SAMPLE_MIN = sample_min(DEF_DAT_W);

endpackage

// File: rtl/delay_line_ctrl_sat_mac.sv
// y = x + ((d * g) >>> GAIN_FRAC), narrowed to DAT_W bits.
// DELAY_LINE_SAT_EN selects saturation; otherwise the sum wraps.
module sat_mac
    import delay_line_pkg::*;
#(
    parameter int DAT_W = DEF_DAT_W
) (
    input  logic signed [DAT_W-1:0] x,
    input  logic signed [DAT_W-1:0] d,
    input  logic        [7:0]       g,
    output logic signed [DAT_W-1:0] y
);

`ifdef DELAY_LINE_SAT_EN
    localparam logic signed [DAT_W-1:0] MAX_V = DAT_W'(sample_max(DAT_W));
    localparam logic signed [DAT_W-1:0] MIN_V = DAT_W'(sample_min(DAT_W));
`endif

    logic signed [DAT_W+8:0] prod;
    logic signed [DAT_W:0]   sum;

    // The gain is zero-extended so a full-scale 255 stays positive in the signed product.
    always_comb begin
        prod = d * $signed({1'b0, g});
        sum  = {x[DAT_W-1], x} + (DAT_W+1)'(prod >>> GAIN_FRAC);
`ifdef DELAY_LINE_SAT_EN
        if (sum[DAT_W] != sum[DAT_W-1]) begin
            y = sum[DAT_W] ? MIN_V : MAX_V;
        end else begin
            y = sum[DAT_W-1:0];
        end
`else
        y = DAT_W'(sum);
`endif
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Echo/delay sequencer driving both ports of the sample RAM.
// Build with DELAY_LINE_SAT_EN to saturate the feedback and mix sums instead of wrapping.
module delay_line_ctrl
    import delay_line_pkg::*;
#(
    parameter int ADR_W = DEF_ADR_W,
    parameter int DAT_W = DEF_DAT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DAT_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DAT_W-1:0] out_data,
    input  logic        [ADR_W-1:0] delay,
    input  logic        [7:0]       fb_gain,
    input  logic        [7:0]       mix_gain,
    output logic                    busy,
    output logic                    ram_en_a,
    output logic                    ram_we_a,
    output logic        [ADR_W-1:0] ram_adr_a,
    output logic signed [DAT_W-1:0] ram_dat_a,
    output logic                    ram_en_b,
    output logic        [ADR_W-1:0] ram_adr_b,
    input  logic signed [DAT_W-1:0] ram_dat_b
);

    state_t                  state;
    logic        [ADR_W-1:0] clr_ptr;
    logic        [ADR_W-1:0] wr_ptr;
    logic        [ADR_W-1:0] delay_q;
    logic signed [DAT_W-1:0] in_q;
    logic        [7:0]       fb_q;
    logic        [7:0]       mix_q;
    logic signed [DAT_W-1:0] d;
    logic signed [DAT_W-1:0] fb_res;
    logic signed [DAT_W-1:0] mix_res;

    // A zero delay would read back the slot about to be overwritten, so force a dry path.
    assign d = (delay_q == '0) ? '0 : ram_dat_b;

    sat_mac #(.DAT_W(DAT_W)) u_fb (
        .x (in_q),
        .d (d),
        .g (fb_q),
        .y (fb_res)
    );

    sat_mac #(.DAT_W(DAT_W)) u_mix (
        .x (in_q),
        .d (d),
        .g (mix_q),
        .y (mix_res)
    );

    // RAM ports are decoded from state so the MIX write can use the read data of the same cycle.
    always_comb begin
        ram_en_a  = 1'b0;
        ram_we_a  = 1'b0;
        ram_adr_a = '0;
        ram_dat_a = '0;
        ram_en_b  = 1'b0;
        ram_adr_b = '0;
        if (rst_n) begin
            case (state)
                CLEAR: begin
                    ram_en_a  = 1'b1;
                    ram_we_a  = 1'b1;
                    ram_adr_a = clr_ptr;
                end
                READ: begin
                    ram_en_b  = 1'b1;
                    ram_adr_b = wr_ptr - delay_q;
                end
                MIX: begin
                    ram_en_a  = 1'b1;
                    ram_we_a  = 1'b1;
                    ram_adr_a = wr_ptr;
                    ram_dat_a = fb_res;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            wr_ptr    <= '0;
            delay_q   <= '0;
            in_q      <= '0;
            fb_q      <= '0;
            mix_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + ADR_W'(1);
                    if (clr_ptr == '1) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        in_q     <= in_data;
                        delay_q  <= delay;
                        fb_q     <= fb_gain;
                        mix_q    <= mix_gain;
                        in_ready <= 1'b0;
                        state    <= READ;
                    end
                end
                READ: begin
                    state <= MIX;
                end
                MIX: begin
                    out_data  <= mix_res;
                    out_valid <= 1'b1;
                    wr_ptr    <= wr_ptr + ADR_W'(1);
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    clr_ptr  <= '0;
                    busy     <= 1'b1;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl (ADR_W=4, DAT_W=8) with a behavioural dual-port RAM.
module tb_delay_line_ctrl;
    import delay_line_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int adr;
        int dat;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic        [AW-1:0] delay;
    logic        [7:0]    fb_gain;
    logic        [7:0]    mix_gain;
    logic                 busy;
    logic                 ram_en_a;
    logic                 ram_we_a;
    logic        [AW-1:0] ram_adr_a;
    logic signed [DW-1:0] ram_dat_a;
    logic                 ram_en_b;
    logic        [AW-1:0] ram_adr_b;
    logic signed [DW-1:0] ram_dat_b;

    logic signed [DW-1:0] ram [DEPTH];

    int   vectors = 0;
    int   miscompares = 0;
    int   mem_m [DEPTH];
    int   wp_m = 0;
    int   exp_out [$];
    wr_t  exp_wr [$];

    always #5 clk = ~clk;

    delay_line_ctrl #(.ADR_W(AW), .DAT_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .delay     (delay),
        .fb_gain   (fb_gain),
        .mix_gain  (mix_gain),
        .busy      (busy),
        .ram_en_a  (ram_en_a),
        .ram_we_a  (ram_we_a),
        .ram_adr_a (ram_adr_a),
        .ram_dat_a (ram_dat_a),
        .ram_en_b  (ram_en_b),
        .ram_adr_b (ram_adr_b),
        .ram_dat_b (ram_dat_b)
    );

    always @(posedge clk) begin
        if (ram_en_a && ram_we_a) ram[ram_adr_a] <= ram_dat_a;
        if (ram_en_b) ram_dat_b <= ram[ram_adr_b];
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int narrow(input int s);
`ifdef DELAY_LINE_SAT_EN
        if (s > SAMPLE_MAX) return SAMPLE_MAX;
        if (s < SAMPLE_MIN) return SAMPLE_MIN;
        return s;
`else
        int w;
        w = s & 255;
        if (w >= 128) w -= 256;
        return w;
`endif
    endfunction

    function automatic int fmac(input int x, input int d, input int g);
        return narrow(x + ((d * g) >>> 8));
    endfunction

    // Output scoreboard: compare on each completed output handshake.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                checkOutput("out_unexpected", int'(out_data), -999);
            end else begin
                checkOutput("out_data", int'(out_data), exp_out.pop_front());
            end
        end
    end

    // Write scoreboard: every sample write outside the clear phase.
    always @(negedge clk) begin
        if (rst_n && ram_en_a && ram_we_a && !busy) begin
            if (exp_wr.size() == 0) begin
                checkOutput("wr_unexpected", int'(ram_adr_a), -999);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                checkOutput("wr_adr", int'(ram_adr_a), e.adr);
                checkOutput("wr_dat", int'(ram_dat_a), e.dat);
            end
        end
    end

    task automatic applyStimulus(input int x, input int dly, input int fb, input int mix);
        int n;
        int d;
        int w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_wait", int'(in_ready), 1);
        d = (dly == 0) ? 0 : mem_m[(wp_m - dly) & (DEPTH - 1)];
        w = fmac(x, d, fb);
        exp_out.push_back(fmac(x, d, mix));
        exp_wr.push_back('{adr: wp_m, dat: w});
        mem_m[wp_m] = w;
        wp_m = (wp_m + 1) & (DEPTH - 1);
        in_valid = 1'b1;
        in_data  = DW'(x);
        delay    = AW'(dly);
        fb_gain  = 8'(fb);
        mix_gain = 8'(mix);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        delay    = AW'($urandom);
        fb_gain  = 8'($urandom);
        mix_gain = 8'($urandom);
    endtask

    task automatic resetAndClear();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_out.delete();
        exp_wr.delete();
        wp_m = 0;
        foreach (mem_m[i]) mem_m[i] = 0;
        checkOutput("rst_busy", int'(busy), 1);
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_en_a", int'(ram_en_a), 0);
        checkOutput("rst_we_a", int'(ram_we_a), 0);
        checkOutput("rst_en_b", int'(ram_en_b), 0);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checkOutput("clr_busy", int'(busy), 1);
            checkOutput("clr_in_ready", int'(in_ready), 0);
            checkOutput("clr_en_we", int'({ram_en_a, ram_we_a}), 3);
            checkOutput("clr_adr", int'(ram_adr_a), i);
            checkOutput("clr_dat", int'(ram_dat_a), 0);
            @(negedge clk);
        end
        checkOutput("clr_done_busy", int'(busy), 0);
        checkOutput("clr_done_in_ready", int'(in_ready), 1);
        checkOutput("clr_done_out_valid", int'(out_valid), 0);
        checkOutput("clr_done_en_a", int'(ram_en_a), 0);
    endtask

    task automatic waitOutValid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("out_valid_rise", int'(out_valid), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_out.size() != 0 || exp_wr.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_out", exp_out.size(), 0);
        checkOutput("drain_wr", exp_wr.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t1 [5] = '{100, 0, 0, 0, 0};
        int t2 [5] = '{64, 0, 0, 0, 0};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        delay     = '0;
        fb_gain   = '0;
        mix_gain  = '0;
        out_ready = 1'b1;

        resetAndClear();

        foreach (t1[i]) applyStimulus(t1[i], 4, 0, 255);
        foreach (t2[i]) applyStimulus(t2[i], 2, 128, 255);
        applyStimulus(120, 1, 0, 255);
        applyStimulus(120, 1, 0, 255);
        drain();

        // Back-pressure: output held, no new input, RAM idle.
        out_ready = 1'b0;
        applyStimulus(50, 3, 64, 128);
        waitOutValid();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("hold_valid", int'(out_valid), 1);
            checkOutput("hold_data", int'(out_data), (exp_out.size() != 0) ? exp_out[0] : -999);
            checkOutput("hold_in_ready", int'(in_ready), 0);
            checkOutput("hold_ram", int'({ram_en_a, ram_en_b}), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_release_valid", int'(out_valid), 0);
        checkOutput("hold_release_in_ready", int'(in_ready), 1);
        drain();

        // Reset while a sample is parked in OUT.
        out_ready = 1'b0;
        applyStimulus(-77, 5, 30, 90);
        waitOutValid();
        resetAndClear();
        out_ready = 1'b1;

        for (int i = 1; i <= 20; i++) applyStimulus(i, 0, 200, 200);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
